johnson_ring_counter_param: RTL and testbench

//  Parametrised twisted-ring (Johnson) / one-hot ring sequencer for phase generation and clock-enable fan-out.

---
 rtl/jrc_pkg.sv | 27 ++
 rtl/jrc_phase_decode.sv | 29 ++
 rtl/johnson_ring_counter_param.sv | 90 +++++++++
 tb/tb_johnson_ring_counter_param.sv | 136 +++++++++++++
 4 files changed

// File: rtl/jrc_pkg.sv
// Shared mode encodings and home/legality helpers for the Johnson/ring sequencer.
// Vectors are carried at a fixed maximum width; callers pass their real width.
package jrc_pkg;
   localparam logic MODE_JOHNSON = 1'b0;
   localparam logic MODE_RING    = 1'b1;
   localparam int   JRC_MAX_W    = 64;

   typedef logic [JRC_MAX_W-1:0] jrc_vec_t;

   function automatic jrc_vec_t jrc_home(input logic mode);
      return (mode == MODE_RING) ? jrc_vec_t'(1) : '0;
   endfunction

   // Johnson: q is 2^k-1 (ones from LSB) or its complement (ones from MSB).
   // Ring: exactly one bit set.
   function automatic logic jrc_legal(input jrc_vec_t q, input logic mode, input int w);
      jrc_vec_t mask;
      jrc_vec_t qm;
      jrc_vec_t inv;
      mask = (w >= JRC_MAX_W) ? '1 : ((jrc_vec_t'(1) << w) - jrc_vec_t'(1));
      qm   = q & mask;
      inv  = ~qm & mask;
      if (mode == MODE_RING)
         return (qm != '0) && ((qm & (qm - jrc_vec_t'(1))) == '0);
      return ((qm & (qm + jrc_vec_t'(1))) == '0) || ((inv & (inv + jrc_vec_t'(1))) == '0);
   endfunction
endpackage

// File: rtl/jrc_phase_decode.sv
// Combinational decode of counter state into its binary phase index plus a legality flag.
// Illegal states report phase 0.
module jrc_phase_decode
   import jrc_pkg::*;
#(
   parameter int W       = 8,
   parameter int PHASE_W = $clog2(2*W)
) (
   input  logic [W-1:0]       q_i,
   input  logic               mode_i,
   output logic [PHASE_W-1:0] phase_o,
   output logic               legal_o
);
   int pc;

   always_comb begin
      legal_o = jrc_legal(jrc_vec_t'(q_i), mode_i, W);
      pc      = $countones(q_i);
      phase_o = '0;
      if (legal_o) begin
         if (mode_i == MODE_JOHNSON) begin
            phase_o = q_i[W-1] ? PHASE_W'(2*W - pc) : PHASE_W'(pc);
         end else begin
            for (int i = 0; i < W; i++)
               if (q_i[i]) phase_o = PHASE_W'(i);
         end
      end
   end
endmodule

// File: rtl/johnson_ring_counter_param.sv
// Parametrised Johnson / one-hot ring sequencer with up/down stepping, load, wrap pulse
// and sticky error flag; illegal states self-correct to the mode's home pattern.
module johnson_ring_counter_param
   import jrc_pkg::*;
#(
   parameter  int W       = 8,
   localparam int PHASE_W = $clog2(2*W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               dir,
   input  logic               mode,
   input  logic               clr,
   input  logic               load,
   input  logic [W-1:0]       load_val,
   output logic [W-1:0]       q,
   output logic [PHASE_W-1:0] phase,
   output logic               wrap,
   output logic               err
);
   localparam logic [PHASE_W-1:0] LAST_JOHNSON = PHASE_W'(2*W - 1);
   localparam logic [PHASE_W-1:0] LAST_RING    = PHASE_W'(W - 1);

   logic [W-1:0] q_q, q_d;
   logic         mode_q, mode_d;
   logic         wrap_q, wrap_d;
   logic         err_q, err_d;
   logic         q_legal;
   logic         load_legal;
   logic [W-1:0] home;
   logic [PHASE_W-1:0] last_phase;

   jrc_phase_decode #(.W(W), .PHASE_W(PHASE_W)) u_decode (
      .q_i     (q_q),
      .mode_i  (mode_q),
      .phase_o (phase),
      .legal_o (q_legal)
   );

   always_comb begin
      q_d        = q_q;
      mode_d     = mode_q;
      wrap_d     = 1'b0;
      err_d      = err_q;
      home       = W'(jrc_home(mode));
      load_legal = jrc_legal(jrc_vec_t'(load_val), mode, W);
      last_phase = (mode_q == MODE_RING) ? LAST_RING : LAST_JOHNSON;

      if (mode != mode_q) begin
         q_d    = home;
         mode_d = mode;
      end else if (clr) begin
         q_d = home;
      end else if (load) begin
         if (load_legal) q_d   = load_val;
         else            err_d = 1'b1;
      end else if (!q_legal) begin
         q_d   = home;
         err_d = 1'b1;
      end else if (en) begin
         // The only difference between the two sequences is the inverted feedback bit.
         if (!dir) begin
            q_d    = {q_q[W-2:0], (mode_q == MODE_RING) ? q_q[W-1] : ~q_q[W-1]};
            wrap_d = (phase == last_phase);
         end else begin
            q_d    = {(mode_q == MODE_RING) ? q_q[0] : ~q_q[0], q_q[W-1:1]};
            wrap_d = (phase == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= W'(jrc_home(mode));
         mode_q <= mode;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         mode_q <= mode_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign q    = q_q;
   assign wrap = wrap_q;
   assign err  = err_q;
endmodule

// File: tb/tb_johnson_ring_counter_param.sv
// Directed vector-table bench for johnson_ring_counter_param at W=8.
module tb_johnson_ring_counter_param;
   logic       clk = 1'b0;
   logic       rst, en, dir, mode, clr, load;
   logic [7:0] load_val;
   logic [7:0] q;
   logic [3:0] phase;
   logic       wrap, err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       en, dir, mode, clr, load;
      logic [7:0] lv;
      logic [7:0] eq;
      logic [3:0] eph;
      logic       ew, ee;
   } vec_t;

   vec_t tv[$];

   johnson_ring_counter_param #(.W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .clr(clr),
      .load(load), .load_val(load_val), .q(q), .phase(phase), .wrap(wrap), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] eq, input logic [3:0] eph,
                          input logic ew, input logic ee);
      chk({tag, ".q"},     32'(q),     32'(eq));
      chk({tag, ".phase"}, 32'(phase), 32'(eph));
      chk({tag, ".wrap"},  32'(wrap),  32'(ew));
      chk({tag, ".err"},   32'(err),   32'(ee));
   endtask

   task automatic add(input logic e, d, m, c, l, input logic [7:0] lv,
                      input logic [7:0] eq, input logic [3:0] eph, input logic ew, ee);
      vec_t v;
      v.en = e; v.dir = d; v.mode = m; v.clr = c; v.load = l; v.lv = lv;
      v.eq = eq; v.eph = eph; v.ew = ew; v.ee = ee;
      tv.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Johnson up through all 16 states and back to 00.
      add(1,0,0,0,0,8'h00, 8'h01, 4'd1,  0,0);
      add(1,0,0,0,0,8'h00, 8'h03, 4'd2,  0,0);
      add(1,0,0,0,0,8'h00, 8'h07, 4'd3,  0,0);
      add(1,0,0,0,0,8'h00, 8'h0F, 4'd4,  0,0);
      add(1,0,0,0,0,8'h00, 8'h1F, 4'd5,  0,0);
      add(1,0,0,0,0,8'h00, 8'h3F, 4'd6,  0,0);
      add(1,0,0,0,0,8'h00, 8'h7F, 4'd7,  0,0);
      add(1,0,0,0,0,8'h00, 8'hFF, 4'd8,  0,0);
      add(1,0,0,0,0,8'h00, 8'hFE, 4'd9,  0,0);
      add(1,0,0,0,0,8'h00, 8'hFC, 4'd10, 0,0);
      add(1,0,0,0,0,8'h00, 8'hF8, 4'd11, 0,0);
      add(1,0,0,0,0,8'h00, 8'hF0, 4'd12, 0,0);
      add(1,0,0,0,0,8'h00, 8'hE0, 4'd13, 0,0);
      add(1,0,0,0,0,8'h00, 8'hC0, 4'd14, 0,0);
      add(1,0,0,0,0,8'h00, 8'h80, 4'd15, 0,0);
      add(1,0,0,0,0,8'h00, 8'h00, 4'd0,  1,0);
      // Down from 00 wraps to the last phase, then hold.
      add(1,1,0,0,0,8'h00, 8'h80, 4'd15, 1,0);
      add(0,1,0,0,0,8'h00, 8'h80, 4'd15, 0,0);
      add(0,0,0,0,0,8'h00, 8'h80, 4'd15, 0,0);
      add(0,1,0,0,0,8'h00, 8'h80, 4'd15, 0,0);
      // Mode change to ring: home with no step, then a full ring lap.
      add(1,0,1,0,0,8'h00, 8'h01, 4'd0,  0,0);
      add(1,0,1,0,0,8'h00, 8'h02, 4'd1,  0,0);
      add(1,0,1,0,0,8'h00, 8'h04, 4'd2,  0,0);
      add(1,0,1,0,0,8'h00, 8'h08, 4'd3,  0,0);
      add(1,0,1,0,0,8'h00, 8'h10, 4'd4,  0,0);
      add(1,0,1,0,0,8'h00, 8'h20, 4'd5,  0,0);
      add(1,0,1,0,0,8'h00, 8'h40, 4'd6,  0,0);
      add(1,0,1,0,0,8'h00, 8'h80, 4'd7,  0,0);
      add(1,0,1,0,0,8'h00, 8'h01, 4'd0,  1,0);
      // Back to Johnson, then loads: illegal rejected, legal accepted.
      add(0,0,0,0,0,8'h00, 8'h00, 4'd0,  0,0);
      add(0,0,0,0,1,8'h5A, 8'h00, 4'd0,  0,1);
      add(0,0,0,0,1,8'h1F, 8'h1F, 4'd5,  0,1);
      // clr beats load and en.
      add(1,0,0,1,1,8'h07, 8'h00, 4'd0,  0,1);
      // Ring down from home wraps to bit 7.
      add(1,1,1,0,0,8'h00, 8'h01, 4'd0,  0,1);
      add(1,1,1,0,0,8'h00, 8'h80, 4'd7,  1,1);

      rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;
      step();
      chk_all("reset", 8'h00, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;

      foreach (tv[i]) begin
         en = tv[i].en; dir = tv[i].dir; mode = tv[i].mode;
         clr = tv[i].clr; load = tv[i].load; load_val = tv[i].lv;
         step();
         chk_all($sformatf("vec%0d", i), tv[i].eq, tv[i].eph, tv[i].ew, tv[i].ee);
      end

      // Reset wins over clr, load and en, and clears err.
      rst = 1'b1; clr = 1'b1; load = 1'b1; load_val = 8'h5A; en = 1'b1; mode = 1'b0; dir = 1'b0;
      step();
      chk_all("rst_all", 8'h00, 4'd0, 1'b0, 1'b0);
      rst = 1'b0; clr = 1'b0; load = 1'b0;
      step();
      chk_all("post_rst_step", 8'h01, 4'd1, 1'b0, 1'b0);

      // Corrupt state: corrected to home with err, no step that cycle.
      force dut.q_q = 8'h24;
      #1;
      release dut.q_q;
      #1;
      chk("illegal.phase", 32'(phase), 32'd0);
      step();
      chk_all("illegal_fix", 8'h00, 4'd0, 1'b0, 1'b1);
      step();
      chk_all("after_fix", 8'h01, 4'd1, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
